core_wb_stage: RTL and testbench
================================

// Module: core_wb_stage
// PURPOSE
//   Writeback stage of the RISC-V core; sits directly upstream of the core register file and drives its write port.
//   Accepts retiring instructions from the MEM stage, waits on the data bus for load responses,
//   aligns and sign-extends load data, and presents one registered write per instruction.
//   Raises a stall request while a load is outstanding; reports a fault if a load response never arrives.
// PARAMETERS
//   LOAD_TIMEOUT  64  cycles spent in S_WAIT without bus_rvalid before load_fault; legal range 2..65535
// PORTS
//   clk           in   1   core clock, all state on posedge
//   rst_sync      in   1   asynchronous, active-high reset (name kept for codebase consistency)
//   stall_n       in   1   pipeline advance enable; low freezes all stage state
//   in_valid      in   1   MEM stage presents a retiring instruction
//   in_ready      out  1   stage can accept; = (state != S_WAIT)
//   in_rd         in   5   destination register index
//   in_rd_wen     in   1   instruction writes rd
//   in_is_load    in   1   instruction is a load; result comes from bus_rdata
//   in_load_op    in   3   load funct3 (load_op_e)
//   in_addr_lo    in   2   byte offset of load address
//   in_result     in   32  ALU/CSR/link result for non-loads
//   bus_rdata     in   32  data bus read word
//   bus_rvalid    in   1   bus_rdata valid this cycle
//   reg_waddr     out  5   register file write index
//   reg_wdata     out  32  register file write data
//   reg_wen       out  1   register file write enable
//   stall_req     out  1   = (state == S_WAIT) && !bus_rvalid
//   load_fault    out  1   one-cycle pulse on load timeout
// BEHAVIOUR
//   Reset: state=S_IDLE, reg_waddr=0, reg_wdata=0, reg_wen=0, load_fault=0, timeout counter=0. Reset at any time,
//     including mid-S_WAIT, abandons the pending instruction with no write.
//   stall_n=0: state, counter and all outputs hold; the register file gates the write with the same stall_n.
//   Accept = in_valid && in_ready && stall_n (evaluated in S_IDLE or S_WRITE; back-to-back accepts allowed).
//   Accepted non-load in cycle N: S_WRITE in N+1 with reg_waddr=in_rd, reg_wdata=in_result,
//     reg_wen = in_rd_wen && (in_rd != 0). Latency 1 cycle.
//   Accepted load in cycle N: latch rd/rd_wen/load_op/addr_lo; S_WAIT in N+1; counter cleared.
//   S_WAIT, bus_rvalid=1 in cycle M: aligned data registered; S_WRITE in M+1 with reg_wen = latched rd_wen && rd!=0.
//   S_WAIT, no rvalid: counter increments; when counter == LOAD_TIMEOUT-1 and no rvalid -> load_fault=1 for
//     one cycle, next state S_IDLE, no write. rvalid in the timeout cycle wins (normal write, no fault).
//   S_WRITE without a new accept -> S_IDLE next cycle with reg_wen=0; reg_waddr/reg_wdata hold last values.
//   bus_rvalid outside S_WAIT is ignored.
//   Alignment (off = addr_lo): LB sext(rdata[8*off+:8]); LBU zext same byte; LH sext(rdata[16*off[1]+:16]);
//     LHU zext same half; LW rdata unmodified (addr_lo ignored). Other funct3 codes: treated as LW.
//   Misalignment detection is upstream's job; no trap raised here.
// STRUCTURE
//   core_pkg: load_op_e (LB=3'b000, LH=3'b001, LW=3'b010, LBU=3'b100, LHU=3'b101),
//     wb_state_e {S_IDLE, S_WRITE, S_WAIT}.
//   Sub-module load_data_align (combinational: rdata, load_op, addr_lo -> 32-bit result).
//   Top: state register, latched load context, timeout counter, output registers.
// TESTING
//   ALU op rd=5 result=0x1234_5678 accepted -> next cycle reg_wen=1, waddr=5, wdata=0x1234_5678; then reg_wen=0.
//   rd=0 with in_rd_wen=1 -> reg_wen stays 0 at the write slot.
//   LB off=3, rvalid 4 cycles after accept with rdata=0x80AA_BBCC -> stall_req high 4 cycles, wdata=0xFFFF_FF80;
//     LHU off=2 same rdata -> 0x0000_80AA.
//   Load, no rvalid, LOAD_TIMEOUT=8 -> load_fault pulse at 8th S_WAIT cycle, no write, in_ready high next;
//     repeat with rvalid in that cycle -> write, no fault.
//   stall_n low for 3 cycles during S_WRITE -> outputs frozen, write completes when stall_n returns; two back-to-back
//     ALU ops -> two consecutive reg_wen cycles.
//   rst_sync asserted mid-S_WAIT -> all outputs zero immediately, later stray rvalid produces no write.

Source files
------------

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared types for the writeback stage
package core_pkg;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_WAIT
  } wb_state_e;

  // Context of a load held while its bus response is outstanding
  typedef struct packed {
    logic [4:0] rd;
    logic       rd_wen;
    logic [2:0] load_op;
    logic [1:0] addr_lo;
  } load_ctx_t;

endpackage

// File: rtl/load_data_align.sv
// rtl/load_data_align.sv - byte/half selection and sign/zero extension of load data
module load_data_align
  import core_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  load_op,
  input  logic [1:0]  addr_lo,
  output logic [31:0] result
);

  logic [31:0] byte_shift;
  logic [31:0] half_shift;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_shift = rdata >> {addr_lo, 3'b000};
  assign half_shift = rdata >> {addr_lo[1], 4'b0000};
  assign byte_sel   = byte_shift[7:0];
  assign half_sel   = half_shift[15:0];

  // Unlisted funct3 codes fall through to the full word
  always_comb begin
    result = rdata;
    case (load_op)
      LB:      result = {{24{byte_sel[7]}}, byte_sel};
      LBU:     result = {24'h0, byte_sel};
      LH:      result = {{16{half_sel[15]}}, half_sel};
      LHU:     result = {16'h0, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/core_wb_stage.sv
// rtl/core_wb_stage.sv - writeback stage driving the register file write port
module core_wb_stage
  import core_pkg::*;
#(
  parameter int unsigned LOAD_TIMEOUT = 64
)
(
  input  logic        clk,
  input  logic        rst_sync,
  input  logic        stall_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rd,
  input  logic        in_rd_wen,
  input  logic        in_is_load,
  input  logic [2:0]  in_load_op,
  input  logic [1:0]  in_addr_lo,
  input  logic [31:0] in_result,
  input  logic [31:0] bus_rdata,
  input  logic        bus_rvalid,
  output logic [4:0]  reg_waddr,
  output logic [31:0] reg_wdata,
  output logic        reg_wen,
  output logic        stall_req,
  output logic        load_fault
);

  localparam logic [15:0] CNT_LAST = 16'(LOAD_TIMEOUT - 1);

  wb_state_e   state, state_nx;
  load_ctx_t   ctx, ctx_nx;
  logic [15:0] cnt, cnt_nx;
  logic [4:0]  waddr_nx;
  logic [31:0] wdata_nx;
  logic        wen_nx;
  logic        fault_nx;
  logic [31:0] aligned;
  logic        accept;

  assign in_ready  = (state != S_WAIT);
  assign stall_req = (state == S_WAIT) && !bus_rvalid;
  assign accept    = in_valid && in_ready && stall_n;

  load_data_align u_align (
    .rdata   (bus_rdata),
    .load_op (ctx.load_op),
    .addr_lo (ctx.addr_lo),
    .result  (aligned)
  );

  always_comb begin
    state_nx = state;
    ctx_nx   = ctx;
    cnt_nx   = cnt;
    waddr_nx = reg_waddr;
    wdata_nx = reg_wdata;
    wen_nx   = 1'b0;
    fault_nx = 1'b0;
    case (state)
      S_IDLE, S_WRITE: begin
        if (accept) begin
          if (in_is_load) begin
            ctx_nx   = '{rd: in_rd, rd_wen: in_rd_wen, load_op: in_load_op, addr_lo: in_addr_lo};
            cnt_nx   = '0;
            state_nx = S_WAIT;
          end else begin
            waddr_nx = in_rd;
            wdata_nx = in_result;
            wen_nx   = in_rd_wen && (in_rd != 5'd0);
            state_nx = S_WRITE;
          end
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_WAIT: begin
        // A response arriving in the timeout cycle still completes normally
        if (bus_rvalid) begin
          waddr_nx = ctx.rd;
          wdata_nx = aligned;
          wen_nx   = ctx.rd_wen && (ctx.rd != 5'd0);
          state_nx = S_WRITE;
        end else if (cnt == CNT_LAST) begin
          fault_nx = 1'b1;
          state_nx = S_IDLE;
        end else begin
          cnt_nx = cnt + 16'd1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_sync) begin
    if (rst_sync) begin
      state      <= S_IDLE;
      ctx        <= '0;
      cnt        <= '0;
      reg_waddr  <= '0;
      reg_wdata  <= '0;
      reg_wen    <= 1'b0;
      load_fault <= 1'b0;
    end else if (stall_n) begin
      state      <= state_nx;
      ctx        <= ctx_nx;
      cnt        <= cnt_nx;
      reg_waddr  <= waddr_nx;
      reg_wdata  <= wdata_nx;
      reg_wen    <= wen_nx;
      load_fault <= fault_nx;
    end
  end

endmodule

// File: tb/tb_core_wb_stage.sv
// tb/tb_core_wb_stage.sv - directed and randomized bench for core_wb_stage
module tb_core_wb_stage;
  import core_pkg::*;

  localparam int LT = 8;

  logic        clk = 1'b0;
  logic        rst_sync;
  logic        stall_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic        in_rd_wen;
  logic        in_is_load;
  logic [2:0]  in_load_op;
  logic [1:0]  in_addr_lo;
  logic [31:0] in_result;
  logic [31:0] bus_rdata;
  logic        bus_rvalid;
  logic [4:0]  reg_waddr;
  logic [31:0] reg_wdata;
  logic        reg_wen;
  logic        stall_req;
  logic        load_fault;

  int n_cmp = 0;
  int n_bad = 0;
  logic [4:0]  exp_waddr;
  logic [31:0] exp_wdata;

  always #5 clk = ~clk;

  core_wb_stage #(.LOAD_TIMEOUT(LT)) dut (
    .clk        (clk),
    .rst_sync   (rst_sync),
    .stall_n    (stall_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_rd      (in_rd),
    .in_rd_wen  (in_rd_wen),
    .in_is_load (in_is_load),
    .in_load_op (in_load_op),
    .in_addr_lo (in_addr_lo),
    .in_result  (in_result),
    .bus_rdata  (bus_rdata),
    .bus_rvalid (bus_rvalid),
    .reg_waddr  (reg_waddr),
    .reg_wdata  (reg_wdata),
    .reg_wen    (reg_wen),
    .stall_req  (stall_req),
    .load_fault (load_fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: pick the addressed byte/half arithmetically, then extend
  function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [1:0] off,
                                           input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * int'(off))) & 32'hFF;
    h = (w >> (16 * (int'(off) / 2))) & 32'hFFFF;
    case (op)
      3'b000:  return (b >= 32'd128)   ? b - 32'd256   : b;
      3'b001:  return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  task automatic check_held(input string tag);
    chk({tag, "_waddr"}, 32'(reg_waddr), 32'(exp_waddr));
    chk({tag, "_wdata"}, reg_wdata, exp_wdata);
  endtask

  task automatic do_idle();
    step();
    chk("idle_wen", 32'(reg_wen), 32'd0);
    check_held("idle");
  endtask

  task automatic do_alu(input logic [4:0] rd, input logic wen, input logic [31:0] res);
    in_valid   = 1'b1;
    in_is_load = 1'b0;
    in_rd      = rd;
    in_rd_wen  = wen;
    in_result  = res;
    in_load_op = 3'($urandom);
    in_addr_lo = 2'($urandom);
    #1 chk("alu_ready", 32'(in_ready), 32'd1);
    step();
    in_valid  = 1'b0;
    exp_waddr = rd;
    exp_wdata = res;
    chk("alu_wen", 32'(reg_wen), 32'(wen && rd != 5'd0));
    check_held("alu");
  endtask

  task automatic do_load(input logic [2:0] op, input logic [1:0] off, input logic [4:0] rd,
                         input logic wen, input int delay, input logic [31:0] word);
    in_valid   = 1'b1;
    in_is_load = 1'b1;
    in_rd      = rd;
    in_rd_wen  = wen;
    in_load_op = op;
    in_addr_lo = off;
    in_result  = $urandom;
    step();
    in_valid   = 1'b0;
    in_is_load = 1'b0;
    chk("ld_ready", 32'(in_ready), 32'd0);
    chk("ld_wen", 32'(reg_wen), 32'd0);
    for (int i = 0; i < delay && i < LT; i++) begin
      bus_rvalid = 1'b0;
      #1 chk("ld_stall", 32'(stall_req), 32'd1);
      step();
    end
    if (delay >= LT) begin
      chk("to_fault", 32'(load_fault), 32'd1);
      chk("to_wen", 32'(reg_wen), 32'd0);
      chk("to_ready", 32'(in_ready), 32'd1);
      check_held("to");
      step();
      chk("to_pulse", 32'(load_fault), 32'd0);
    end else begin
      bus_rvalid = 1'b1;
      bus_rdata  = word;
      #1 chk("ld_stall_rv", 32'(stall_req), 32'd0);
      step();
      bus_rvalid = 1'b0;
      bus_rdata  = $urandom;
      exp_waddr  = rd;
      exp_wdata  = ref_load(op, off, word);
      chk("ld_wen_done", 32'(reg_wen), 32'(wen && rd != 5'd0));
      chk("ld_fault", 32'(load_fault), 32'd0);
      check_held("ld");
    end
  endtask

  initial begin
    logic [31:0] r;
    rst_sync   = 1'b1;
    stall_n    = 1'b1;
    in_valid   = 1'b0;
    in_rd      = '0;
    in_rd_wen  = 1'b0;
    in_is_load = 1'b0;
    in_load_op = '0;
    in_addr_lo = '0;
    in_result  = '0;
    bus_rdata  = '0;
    bus_rvalid = 1'b0;
    exp_waddr  = '0;
    exp_wdata  = '0;
    step();
    step();
    chk("rst_wen", 32'(reg_wen), 32'd0);
    chk("rst_fault", 32'(load_fault), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_stall", 32'(stall_req), 32'd0);
    check_held("rst");
    rst_sync = 1'b0;
    step();

    do_alu(5'd5, 1'b1, 32'h1234_5678);
    do_idle();
    do_alu(5'd0, 1'b1, $urandom);
    do_idle();

    do_load(LB, 2'd3, 5'd7, 1'b1, 4, 32'h80AA_BBCC);
    chk("lb_const", reg_wdata, 32'hFFFF_FF80);
    do_idle();
    do_load(LHU, 2'd2, 5'd9, 1'b1, 4, 32'h80AA_BBCC);
    chk("lhu_const", reg_wdata, 32'h0000_80AA);
    do_idle();

    do_load(LW, 2'd0, 5'd3, 1'b1, LT, $urandom);
    do_load(LW, 2'd0, 5'd3, 1'b1, LT - 1, 32'hDEAD_BEEF);
    chk("to_edge_data", reg_wdata, 32'hDEAD_BEEF);
    do_idle();

    do_alu(5'd12, 1'b1, 32'hCAFE_F00D);
    stall_n    = 1'b0;
    in_valid   = 1'b1;
    in_rd      = 5'd20;
    in_rd_wen  = 1'b1;
    in_result  = $urandom;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_wen", 32'(reg_wen), 32'd1);
      check_held("stall");
    end
    in_valid = 1'b0;
    stall_n  = 1'b1;
    do_idle();

    do_alu(5'd1, 1'b1, $urandom);
    do_alu(5'd2, 1'b1, $urandom);
    do_idle();

    in_valid   = 1'b1;
    in_is_load = 1'b1;
    in_rd      = 5'd4;
    in_rd_wen  = 1'b1;
    step();
    in_valid   = 1'b0;
    in_is_load = 1'b0;
    step();
    rst_sync = 1'b1;
    exp_waddr = '0;
    exp_wdata = '0;
    #1;
    chk("mrst_wen", 32'(reg_wen), 32'd0);
    chk("mrst_fault", 32'(load_fault), 32'd0);
    chk("mrst_ready", 32'(in_ready), 32'd1);
    chk("mrst_stall", 32'(stall_req), 32'd0);
    check_held("mrst");
    step();
    rst_sync   = 1'b0;
    bus_rvalid = 1'b1;
    bus_rdata  = $urandom;
    step();
    bus_rvalid = 1'b0;
    chk("stray_wen", 32'(reg_wen), 32'd0);
    check_held("stray");

    for (int n = 0; n < 30; n++) begin
      r = $urandom;
      if (r[0]) begin
        do_alu(5'($urandom), r[1], $urandom);
      end else begin
        do_load(3'($urandom), 2'($urandom), 5'($urandom), r[1],
                (r[7:4] == 4'd0) ? LT : int'($urandom_range(0, 5)), $urandom);
      end
      if (r[2]) do_idle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
